accel_uart_framer: RTL

- Synchronous command/response sequencer between async_receiver/async_transmitter and spi_ee_config on the DE0-Nano serial link.
- Decodes single-byte axis commands from the Raspberry Pi and drives the axis select to the accelerometer reader.
- Waits for a fresh sample, captures it coherently, and streams a 4-byte reply frame through the transmitter using a proper start/busy handshake.
- Replaces the ad-hoc, busy-edge-clocked reply logic in the serial top level.

---
 rtl/accel_uart_framer.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/accel_uart_framer.sv
`default_nettype none
// ============================================================================
//  Module   : accel_uart_framer
//  Purpose  : Command/response sequencer for the DE0-Nano serial link.
//             Decodes a single-byte axis command ('x'/'y'/'z'), steers the
//             accelerometer axis select, waits for the reading to settle,
//             captures it coherently and streams a 4-byte reply frame
//             through the UART transmitter using a start/busy handshake.
//  Revision : 1.0  initial release
// ============================================================================
module accel_uart_framer #(
  parameter int unsigned SETTLE_CYCLES = 2500,
  parameter logic [7:0]  SYNC_BYTE     = 8'h00,
  parameter int unsigned BUSY_TIMEOUT  = 64
) (
  input  logic        CLK_50,
  input  logic        areset,
  input  logic [7:0]  rx_data,
  input  logic        rx_data_ready,
  input  logic [15:0] sample,
  output logic [2:0]  dimension,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        frame_active,
  output logic        cmd_dropped
);

  // One down-counter is shared between the settle delay and the busy
  // timeout, since the two are never in use at the same time.
  localparam int unsigned c_CNT_MAX =
      (SETTLE_CYCLES > BUSY_TIMEOUT) ? (SETTLE_CYCLES - 1) : (BUSY_TIMEOUT - 1);
  localparam int unsigned c_CNT_W =
      (c_CNT_MAX < 1) ? 1 : $clog2(c_CNT_MAX + 1);

  localparam logic [c_CNT_W-1:0] c_SETTLE_LOAD = c_CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_BUSY_LOAD   = c_CNT_W'(BUSY_TIMEOUT - 1);

  // Command bytes accepted from the host.
  localparam logic [7:0] c_CMD_X = 8'h78;
  localparam logic [7:0] c_CMD_Y = 8'h79;
  localparam logic [7:0] c_CMD_Z = 8'h7A;

  // Sequencer states.
  localparam logic [2:0] c_ST_IDLE    = 3'd0;
  localparam logic [2:0] c_ST_SETTLE  = 3'd1;
  localparam logic [2:0] c_ST_START   = 3'd2;
  localparam logic [2:0] c_ST_WAIT_HI = 3'd3;
  localparam logic [2:0] c_ST_WAIT_LO = 3'd4;

  logic [2:0]         state_q,     state_d;
  logic [c_CNT_W-1:0] cnt_q,       cnt_d;
  logic [1:0]         idx_q,       idx_d;
  logic [2:0]         dim_q,       dim_d;
  logic [15:0]        shadow_q,    shadow_d;
  logic [7:0]         tx_data_q,   tx_data_d;
  logic               tx_start_q,  tx_start_d;
  logic               drop_q,      drop_d;
  logic               active_q,    active_d;

  logic               w_cmd_valid;
  logic [2:0]         w_cmd_axis;
  logic [7:0]         w_frame_byte;

  // Decode the received byte into an axis index; anything else is ignored.
  always_comb begin
    w_cmd_valid = 1'b1;
    w_cmd_axis  = 3'd0;
    case (rx_data)
      c_CMD_X: w_cmd_axis = 3'd0;
      c_CMD_Y: w_cmd_axis = 3'd1;
      c_CMD_Z: w_cmd_axis = 3'd2;
      default: w_cmd_valid = 1'b0;
    endcase
  end

  // Select the reply byte for the current frame position (sync, axis, LSB, MSB).
  always_comb begin
    case (idx_q)
      2'd0:    w_frame_byte = SYNC_BYTE;
      2'd1:    w_frame_byte = {5'b0, dim_q};
      2'd2:    w_frame_byte = shadow_q[7:0];
      default: w_frame_byte = shadow_q[15:8];
    endcase
  end

  // Next-state logic for the command/settle/transmit sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    dim_d      = dim_q;
    shadow_d   = shadow_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    drop_d     = 1'b0;

    case (state_q)
      c_ST_IDLE: begin
        if (rx_data_ready && w_cmd_valid) begin
          dim_d   = w_cmd_axis;
          cnt_d   = c_SETTLE_LOAD;
          state_d = c_ST_SETTLE;
        end
      end

      c_ST_SETTLE: begin
        // The reading is sampled exactly once, when the settle count expires,
        // so all reply bytes come from the same measurement.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shadow_d = sample;
          idx_d    = 2'd0;
          state_d  = c_ST_START;
        end
      end

      c_ST_START: begin
        if (!tx_busy) begin
          tx_data_d  = w_frame_byte;
          tx_start_d = 1'b1;
          cnt_d      = c_BUSY_LOAD;
          state_d    = c_ST_WAIT_HI;
        end
      end

      c_ST_WAIT_HI: begin
        // A transmitter that never raises busy must not hang the frame.
        if (tx_busy || (cnt_q == '0)) begin
          state_d = c_ST_WAIT_LO;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      c_ST_WAIT_LO: begin
        if (!tx_busy) begin
          if (idx_q == 2'd3) begin
            state_d = c_ST_IDLE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = c_ST_START;
          end
        end
      end

      default: begin
        state_d = c_ST_IDLE;
      end
    endcase

    // Any byte arriving while a command is in flight is discarded and flagged.
    if (rx_data_ready && (state_q != c_ST_IDLE)) begin
      drop_d = 1'b1;
    end

    active_d = (state_d != c_ST_IDLE);
  end

  // State and output registers; reset aborts any frame in progress.
  always_ff @(posedge CLK_50 or posedge areset) begin
    if (areset) begin
      state_q    <= c_ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= 2'd0;
      dim_q      <= 3'd0;
      shadow_q   <= 16'd0;
      tx_data_q  <= 8'd0;
      tx_start_q <= 1'b0;
      drop_q     <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      dim_q      <= dim_d;
      shadow_q   <= shadow_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      drop_q     <= drop_d;
      active_q   <= active_d;
    end
  end

  assign dimension    = dim_q;
  assign tx_data      = tx_data_q;
  assign tx_start     = tx_start_q;
  assign cmd_dropped  = drop_q;
  assign frame_active = active_q;

endmodule
`default_nettype wire
